// File: rtl/cmd_asm_pkg.sv
// cmd_asm_pkg: types and constants shared by the command assembler and its
// timeout sub-module.
//   opc_t           8-bit opcode
//   cmd_t           32-bit long-command parameter word
//   CMD_PARAM_BYTES number of parameter bytes following a long opcode
//   LONG_OPC_BIT    opcode bit that marks a long command
//   state_t         assembler FSM states
package cmd_asm_pkg;

    typedef logic [7:0]  opc_t;
    typedef logic [31:0] cmd_t;

    localparam int CMD_PARAM_BYTES = 4;
    localparam int LONG_OPC_BIT    = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        PARAM = 1'b1
    } state_t;

    // True when the byte opens a long command (opcode + parameter bytes).
    function automatic logic is_long(input opc_t b);
        return b[LONG_OPC_BIT];
    endfunction

endpackage

// File: rtl/cmd_asm_tmo.sv
// tmo_cnt: inter-byte timeout counter.
//   clk_i   clock, rising edge
//   rst_in  asynchronous active-low reset
//   clr_i   clear counter to zero (has priority over en_i)
//   en_i    count one cycle
//   exp_o   combinational pulse: counter sits at LIMIT-1, enabled, not cleared
// LIMIT = 0 disables the counter entirely (exp_o never asserts).
module tmo_cnt
    import cmd_asm_pkg::*;
#(
    parameter int LIMIT = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_in,
    input  logic clr_i,
    input  logic en_i,
    output logic exp_o
);

    // Width holds the value LIMIT itself; a 1-bit counter when disabled.
    localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [W-1:0] LAST = W'((LIMIT > 0) ? (LIMIT - 1) : 0);
    localparam logic [W-1:0] SAT  = W'((LIMIT > 0) ? LIMIT : 0);

    logic [W-1:0] cnt_r;

    // Saturating cycle counter; never wraps back to zero on its own.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt_r <= '0;
        end else if (clr_i) begin
            cnt_r <= '0;
        end else if (en_i && (cnt_r != SAT)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A byte arriving in the same cycle (clr_i) cancels the expiry.
    assign exp_o = (LIMIT != 0) && en_i && !clr_i && (cnt_r == LAST);

endmodule

// File: rtl/cmd_asm.sv
// cmd_asm: assembles UART bytes into decoder commands.
// A byte with bit 7 clear is a complete short command; a byte with bit 7 set
// is a long opcode followed by four parameter bytes (first byte = LSB).
//   clk_i   clock, rising edge          rst_in  async active-low reset
//   stb_i   received-byte valid pulse   dat_i   received byte
//   stb_o   assembled-command pulse     opc_o   opcode (held)
//   cmd_o   parameter word (held, 0 for short commands)
//   err_o   pulse when a partial long command is dropped by timeout
//   busy_o  high while parameter bytes are outstanding
module cmd_asm
    import cmd_asm_pkg::*;
#(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        stb_i,
    input  logic [7:0]  dat_i,
    output logic        stb_o,
    output logic [7:0]  opc_o,
    output logic [31:0] cmd_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int IDXW = $clog2(CMD_PARAM_BYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CMD_PARAM_BYTES - 1);

    state_t          state_r, state_s;
    logic [IDXW-1:0] idx_r, idx_s;
    cmd_t            sh_r, sh_s;
    opc_t            lop_r, lop_s;
    logic            stb_r, stb_s;
    logic            err_r, err_s;
    opc_t            opc_r, opc_s;
    cmd_t            cmd_r, cmd_s;
    logic            tmo_exp_s;
    logic            in_param_s;

    assign in_param_s = (state_r == PARAM);

    // Counter runs only while waiting for parameter bytes; any byte restarts it.
    tmo_cnt #(.LIMIT(TIMEOUT)) u_tmo (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .clr_i  (stb_i || !in_param_s),
        .en_i   (in_param_s),
        .exp_o  (tmo_exp_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        sh_s    = sh_r;
        lop_s   = lop_r;
        stb_s   = 1'b0;
        err_s   = 1'b0;
        opc_s   = opc_r;
        cmd_s   = cmd_r;
        case (state_r)
            IDLE: begin
                if (stb_i) begin
                    if (is_long(dat_i)) begin
                        lop_s   = dat_i;
                        idx_s   = '0;
                        sh_s    = '0;
                        state_s = PARAM;
                    end else begin
                        stb_s   = 1'b1;
                        opc_s   = dat_i;
                        cmd_s   = '0;
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            PARAM: begin
                if (stb_i) begin
                    // Parameter bytes are pure data, whatever their bit 7.
                    sh_s[{idx_r, 3'b000} +: 8] = dat_i;
                    idx_s = idx_r + IDXW'(1);
                    if (idx_r == LAST_IDX) begin
                        stb_s   = 1'b1;
                        opc_s   = lop_r;
                        cmd_s   = sh_s;
                        state_s = IDLE;
                    end else begin
                        state_s = PARAM;
                    end
                end else if (tmo_exp_s) begin
                    err_s   = 1'b1;
                    idx_s   = '0;
                    sh_s    = '0;
                    state_s = IDLE;
                end else begin
                    state_s = PARAM;
                end
            end
            default: begin
                idx_s   = '0;
                sh_s    = '0;
                state_s = IDLE;
            end
        endcase
    end

    // State, assembly and output registers.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= IDLE;
            idx_r   <= '0;
            sh_r    <= '0;
            lop_r   <= 8'h00;
            stb_r   <= 1'b0;
            err_r   <= 1'b0;
            opc_r   <= 8'h00;
            cmd_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            sh_r    <= sh_s;
            lop_r   <= lop_s;
            stb_r   <= stb_s;
            err_r   <= err_s;
            opc_r   <= opc_s;
            cmd_r   <= cmd_s;
        end
    end

    assign stb_o  = stb_r;
    assign err_o  = err_r;
    assign opc_o  = opc_r;
    assign cmd_o  = cmd_r;
    assign busy_o = in_param_s;

endmodule

// File: tb/tb_cmd_asm.sv
// tb_cmd_asm: directed and random stimulus for cmd_asm (TIMEOUT=16), checked
// every cycle against a byte-queue reference model.
module tb_cmd_asm;

    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_in;
    logic        stb_i;
    logic [7:0]  dat_i;
    logic        stb_o;
    logic [7:0]  opc_o;
    logic [31:0] cmd_o;
    logic        err_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: bytes of the pending long command, idle gap.
    logic [7:0]  pend[$];
    int          gap = 0;
    logic        e_stb = 1'b0;
    logic        e_err = 1'b0;
    logic        e_busy = 1'b0;
    logic [7:0]  e_opc = 8'h00;
    logic [31:0] e_cmd = 32'h0;

    cmd_asm #(.TIMEOUT(TMO)) dut (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .stb_i  (stb_i),
        .dat_i  (dat_i),
        .stb_o  (stb_o),
        .opc_o  (opc_o),
        .cmd_o  (cmd_o),
        .err_o  (err_o),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("stb_o",  32'(stb_o),  32'(e_stb));
        chk("err_o",  32'(err_o),  32'(e_err));
        chk("busy_o", 32'(busy_o), 32'(e_busy));
        chk("opc_o",  32'(opc_o),  32'(e_opc));
        chk("cmd_o",  cmd_o,       e_cmd);
    endtask

    // Expected outputs after the clock edge that samples (s, d).
    task automatic model(input logic s, input logic [7:0] d);
        e_stb = 1'b0;
        e_err = 1'b0;
        if (s) begin
            gap = 0;
            if (pend.size() == 0 && d[7] == 1'b0) begin
                e_stb = 1'b1;
                e_opc = d;
                e_cmd = 32'h0;
            end else begin
                pend.push_back(d);
                if (pend.size() == 5) begin
                    e_stb = 1'b1;
                    e_opc = pend[0];
                    e_cmd = {pend[4], pend[3], pend[2], pend[1]};
                    pend.delete();
                end
            end
        end else if (pend.size() != 0) begin
            gap++;
            if (gap == TMO) begin
                e_err = 1'b1;
                pend.delete();
            end
        end
        e_busy = (pend.size() != 0);
    endtask

    task automatic cyc(input logic s, input logic [7:0] d);
        stb_i = s;
        dat_i = d;
        model(s, d);
        @(posedge clk_i);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00);
    endtask

    initial begin
        rst_in = 1'b0;
        stb_i  = 1'b0;
        dat_i  = 8'h00;
        #12;
        check_all();
        rst_in = 1'b1;

        // Short command 0x00.
        cyc(1'b1, 8'h00);
        chk("short_stb", 32'(stb_o), 32'd1);
        chk("short_cmd", cmd_o, 32'h0000_0000);
        idle(2);

        // Long command with idle gaps between bytes.
        cyc(1'b1, 8'hC0);
        chk("long_busy", 32'(busy_o), 32'd1);
        idle(2);
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22);
        idle(1);
        cyc(1'b1, 8'h33);
        cyc(1'b1, 8'h44);
        chk("long_opc", 32'(opc_o), 32'h0000_00C0);
        chk("long_cmd", cmd_o, 32'h4433_2211);
        idle(3);

        // Back-to-back bytes, next opcode taken as the command completes.
        cyc(1'b1, 8'h80);
        repeat (4) cyc(1'b1, 8'hFF);
        chk("b2b_cmd1", cmd_o, 32'hFFFF_FFFF);
        cyc(1'b1, 8'h01);
        chk("b2b_stb2", 32'(stb_o), 32'd1);
        chk("b2b_opc2", 32'(opc_o), 32'h0000_0001);
        chk("b2b_cmd2", cmd_o, 32'h0);
        idle(2);

        // Timeout after 16 idle cycles.
        cyc(1'b1, 8'hC2);
        cyc(1'b1, 8'hAA);
        idle(16);
        chk("tmo_err", 32'(err_o), 32'd1);
        chk("tmo_stb", 32'(stb_o), 32'd0);
        idle(2);
        cyc(1'b1, 8'h02);
        chk("tmo_next_opc", 32'(opc_o), 32'h0000_0002);
        idle(2);

        // Gaps of exactly 15 idle cycles do not time out.
        cyc(1'b1, 8'hC3);
        cyc(1'b1, 8'h01);
        idle(15);
        cyc(1'b1, 8'h02);
        idle(15);
        cyc(1'b1, 8'h03);
        idle(15);
        cyc(1'b1, 8'h04);
        chk("edge_stb", 32'(stb_o), 32'd1);
        chk("edge_cmd", cmd_o, 32'h0403_0201);
        idle(2);

        // Reset in the middle of a long command.
        cyc(1'b1, 8'hC0);
        cyc(1'b1, 8'h11);
        rst_in = 1'b0;
        pend.delete();
        gap    = 0;
        e_stb  = 1'b0;
        e_err  = 1'b0;
        e_busy = 1'b0;
        e_opc  = 8'h00;
        e_cmd  = 32'h0;
        #2;
        check_all();
        @(posedge clk_i);
        #1;
        rst_in = 1'b1;
        idle(3);
        cyc(1'b1, 8'h11);
        chk("rst_short_opc", 32'(opc_o), 32'h0000_0011);
        chk("rst_short_stb", 32'(stb_o), 32'd1);

        // Random bytes, random strobes and occasional long gaps.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                idle(int'($urandom_range(13, 18)));
            end else begin
                cyc(1'($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)));
            end
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
